eth_tx_arbiter: RTL and testbench
=================================

// Module: eth_tx_arbiter
// PURPOSE
//   Shares the single MII transmit path between NUM_REQ frame sources (ARP reply, ICMP echo reply, UDP tx).
//   Round-robin, frame-granular arbitration; enforces inter-frame gap (IFG); truncates/drains runaway frames.
//   Sits between the protocol engines and the MAC/MII tx serializer in the 25 MHz PHY clock domain.
// PARAMETERS
//   NUM_REQ          3     number of requesters (2..8)
//   IFG_CYCLES       24    idle clocks after last output beat before next grant (12 bytes @ 2 nibbles/byte)
//   MAX_FRAME_BYTES  1518  output beats per frame before forced truncation (>=2)
// PORTS
//   i_clock          in   1          PHY tx clock; all logic on rising edge
//   i_reset_n        in   1          synchronous, active-low reset
//   i_req_valid      in   NUM_REQ    per-requester byte valid
//   i_req_data       in   8*NUM_REQ  per-requester byte; requester k at [8k+7:8k]
//   i_req_last       in   NUM_REQ    per-requester last byte of frame
//   o_req_ready      out  NUM_REQ    per-requester byte accepted
//   o_tx_valid       out  1          byte valid to serializer
//   o_tx_data        out  8          byte to serializer
//   o_tx_last        out  1          last byte of frame
//   i_tx_ready       in   1          serializer accepts byte
//   o_grant          out  NUM_REQ    one-hot current owner; 0 when none
//   o_busy           out  1          high in any state other than IDLE
//   o_overrun        out  1          1-clock pulse on forced truncation
//   o_frame_count    out  16         completed output frames, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset: state=IDLE, o_grant=0, o_req_ready=0, o_tx_valid=0, o_tx_last=0, o_tx_data=0, o_busy=0,
//     o_overrun=0, o_frame_count=0, rr pointer=0 (requester 0 highest priority first), byte counter=0.
//   Handshake: beat transfers when valid&ready are high on the same edge; valid must not depend on ready.
//   FSM IDLE: if any i_req_valid, pick first set index searching ptr, ptr+1, ... mod NUM_REQ;
//     register o_grant=onehot(k), ptr<=k+1 mod NUM_REQ, go XFER. Grant visible the clock after request.
//   XFER: o_tx_valid=i_req_valid[k], o_tx_data=i_req_data[k], o_req_ready[k]=i_tx_ready (combinational,
//     zero latency); other ready bits 0. Count beats; on beat with i_req_last[k]: frame_count++,
//     grant cleared, go IFG.
//   Overrun: beat number MAX_FRAME_BYTES without last -> o_tx_last forced 1 on that beat, o_overrun pulse,
//     frame_count++; if that beat carried i_req_last go IFG, else go DRAIN.
//   DRAIN: o_grant kept, o_req_ready[k]=1, o_tx_valid=0; discard bytes until i_req_last[k] beat -> IFG.
//   IFG: counter loads IFG_CYCLES-1, decrements each clock; all ready 0; at 0 go IDLE (arbitrate next clock).
//     IFG_CYCLES=0 -> skip IFG, go IDLE directly.
//   Requesters dropping valid mid-frame: output valid drops, grant held (no preemption, no timeout).
//   Requests raised during XFER/DRAIN/IFG wait; ptr ensures no requester waits more than NUM_REQ-1 frames.
//   Reset mid-frame: immediate return to reset values next clock; partial frame is abandoned.
// TESTING
//   1) Req1 sends 64-byte frame, tx_ready=1 -> grant=3'b010 one clock after valid, 64 beats, last on
//      byte 64, frame_count=1, next grant no earlier than 24 idle clocks after last beat.
//   2) Req0,1,2 all valid at once, repeated frames -> grant order 0,1,2,0,1,2; each exactly once per round.
//   3) Random i_tx_ready deasserts (50%) during req2 frame -> output byte stream identical to input,
//      no duplicate/lost bytes, o_req_ready[2] mirrors i_tx_ready.
//   4) MAX_FRAME_BYTES=64, req0 sends 100-byte frame -> 64 output beats, tx_last on beat 64,
//      o_overrun one pulse, remaining 36 bytes drained with tx_valid=0, then IFG.
//   5) i_reset_n=0 for one clock at byte 10 of a frame -> next clock all outputs at reset values,
//      frame_count=0; new frame from req2 afterwards granted normally.
//   6) Preload frame_count to 0xFFFF via 65535 minimum frames (or force) -> next frame wraps count to 0.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter that shares the MII transmit path between NUM_REQ sources.
// Enforces the inter-frame gap and truncates/drains frames that exceed MAX_FRAME_BYTES.
module eth_tx_arbiter #(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned IFG_CYCLES      = 24,
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_tx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_last,
  input  logic                   i_tx_ready,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_busy,
  output logic                   o_overrun,
  output logic [15:0]            o_frame_count
);

  localparam int unsigned PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BW       = (MAX_FRAME_BYTES > 1) ? $clog2(MAX_FRAME_BYTES) : 1;
  localparam int unsigned IW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int unsigned IFG_LOAD = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_IFG   = 2'd3
  } state_e;

  // With no gap configured a finished frame returns straight to arbitration.
  localparam state_e AFTER_FRAME = (IFG_CYCLES > 0) ? ST_IFG : ST_IDLE;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [IW-1:0]        ifg_q, ifg_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 overrun_q, overrun_d;

  logic [7:0]           req_data [NUM_REQ];
  logic                 arb_found;
  logic [PW-1:0]        arb_sel;
  logic                 own_valid;
  logic                 own_last;
  logic                 at_max;
  logic                 beat;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data[g] = i_req_data[8*g +: 8];
  end

  assign own_valid = i_req_valid[owner_q];
  assign own_last  = i_req_last[owner_q];
  assign at_max    = (beat_q == BW'(MAX_FRAME_BYTES - 1));
  assign beat      = (state_q == ST_XFER) && own_valid && i_tx_ready;

  // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr_q) + i) % NUM_REQ;
      if (!arb_found && i_req_valid[PW'(cand)]) begin
        arb_found = 1'b1;
        arb_sel   = PW'(cand);
      end
    end
  end

  // State register and datapath flops.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      beat_q      <= '0;
      ifg_q       <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      beat_q      <= beat_d;
      ifg_q       <= ifg_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    ifg_d       = ifg_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d = ST_XFER;
          owner_d = arb_sel;
          grant_d = NUM_REQ'(1) << arb_sel;
          ptr_d   = (arb_sel == PW'(NUM_REQ - 1)) ? '0 : arb_sel + PW'(1);
          beat_d  = '0;
        end
      end
      ST_XFER: begin
        if (beat) begin
          beat_d = beat_q + BW'(1);
          if (own_last || at_max) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
          if (at_max && !own_last) begin
            overrun_d = 1'b1;
            state_d   = ST_DRAIN;
          end else if (own_last) begin
            grant_d = '0;
            ifg_d   = IW'(IFG_LOAD);
            state_d = AFTER_FRAME;
          end
        end
      end
      ST_DRAIN: begin
        if (own_valid && own_last) begin
          grant_d = '0;
          ifg_d   = IW'(IFG_LOAD);
          state_d = AFTER_FRAME;
        end
      end
      ST_IFG: begin
        if (ifg_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          ifg_d = ifg_q - IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero-latency path from the owning requester to the serializer.
  always_comb begin
    o_req_ready = '0;
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    o_tx_last   = 1'b0;
    case (state_q)
      ST_XFER: begin
        o_tx_valid  = own_valid;
        o_tx_data   = req_data[owner_q];
        o_tx_last   = own_valid && (own_last || at_max);
        o_req_ready = grant_q & {NUM_REQ{i_tx_ready}};
      end
      ST_DRAIN: o_req_ready = grant_q;
      default: ;
    endcase
  end

  assign o_grant       = grant_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_overrun     = overrun_q;
  assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: table-driven round-robin vectors plus
// directed sequences for IFG, backpressure, truncation, mid-frame reset and count wrap.
module tb_eth_tx_arbiter;

  localparam int unsigned NR   = 3;
  localparam int unsigned IFG  = 24;
  localparam int unsigned MAXB = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_last;
  logic              tx_ready;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              overrun;
  logic [15:0]       frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] out_q [$];
  int         last_seen = 0;
  int         ovr_seen  = 0;

  always #5 clk = ~clk;

  eth_tx_arbiter #(
    .NUM_REQ        (NR),
    .IFG_CYCLES     (IFG),
    .MAX_FRAME_BYTES(MAXB)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_last   (req_last),
    .o_req_ready  (req_ready),
    .o_tx_valid   (tx_valid),
    .o_tx_data    (tx_data),
    .o_tx_last    (tx_last),
    .i_tx_ready   (tx_ready),
    .o_grant      (grant),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_frame_count(frame_count)
  );

  // Output-side monitor: values are stable mid-cycle and transfer on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        out_q.push_back(tx_data);
        if (tx_last) last_seen++;
      end
      if (overrun) ovr_seen++;
    end
  end

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_grant;
    logic [7:0]    exp_data;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"},   32'(grant),       32'h0);
    check({tag, "_ready"},   32'(req_ready),   32'h0);
    check({tag, "_txvalid"}, 32'(tx_valid),    32'h0);
    check({tag, "_txlast"},  32'(tx_last),     32'h0);
    check({tag, "_txdata"},  32'(tx_data),     32'h0);
    check({tag, "_busy"},    32'(busy),        32'h0);
    check({tag, "_overrun"}, 32'(overrun),     32'h0);
    check({tag, "_fcount"},  32'(frame_count), 32'h0);
  endtask

  task automatic set_byte(input int k, input logic [7:0] d, input logic l);
    req_data[8*k +: 8] = d;
    req_last[k]        = l;
  endtask

  task automatic drive_idle();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string name, output int cycles);
    cycles = 0;
    while (grant == '0 && cycles < 200) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (grant == '0) begin
      n_fail++;
      $display("FAIL %s: no grant after %0d clocks, expected a grant", name, cycles);
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 200) begin
      tick();
      c++;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s: busy still 1 after %0d clocks, expected 0", name, c);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    int          exp_frames;
    int          gap;
    int          errs;
    logic [7:0]  in3 [40];

    // ptr starts at 0; expected owners follow the round-robin pointer across the table.
    vecs[0] = '{3'b010, 3'b010, 8'hA1};
    vecs[1] = '{3'b011, 3'b001, 8'hA0};
    vecs[2] = '{3'b111, 3'b010, 8'hA1};
    vecs[3] = '{3'b111, 3'b100, 8'hA2};
    vecs[4] = '{3'b111, 3'b001, 8'hA0};
    vecs[5] = '{3'b101, 3'b100, 8'hA2};
    vecs[6] = '{3'b110, 3'b010, 8'hA1};
    vecs[7] = '{3'b001, 3'b001, 8'hA0};

    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Req1 sends a 64-byte frame that ends exactly on the truncation boundary.
    out_q.delete(); last_seen = 0; ovr_seen = 0;
    req_valid = 3'b010;
    set_byte(1, 8'h30, 1'b0);
    #1;
    check("t1_grant_before", 32'(grant), 32'h0);
    tick();
    check("t1_grant", 32'(grant), 32'h2);
    for (int b = 0; b < 64; b++) begin
      set_byte(1, 8'(8'h30 + b), b == 63);
      #1;
      if (b == 0)  check("t1_first_data", 32'(tx_data), 32'h30);
      if (b == 63) check("t1_last_flag", 32'({tx_valid, tx_last, req_ready}), 32'b11_010);
      tick();
    end
    req_valid = '0;
    check("t1_fcount", 32'(frame_count), 32'd1);
    check("t1_grant_clr", 32'(grant), 32'h0);
    check("t1_busy_ifg", 32'(busy), 32'h1);
    check("t1_beats", 32'(out_q.size()), 32'd64);
    check("t1_lasts", 32'(last_seen), 32'd1);
    check("t1_no_ovr", 32'(ovr_seen), 32'd0);
    errs = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] != 8'(8'h30 + i)) errs++;
    check("t1_stream", 32'(errs), 32'd0);
    req_valid = 3'b001;
    set_byte(0, 8'h55, 1'b1);
    wait_grant("t1_ifg_wait", gap);
    check("t1_ifg_gap", 32'(gap), 32'(IFG + 1));
    check("t1_next_grant", 32'(grant), 32'h1);
    tick();
    req_valid = '0;
    check("t1_fcount2", 32'(frame_count), 32'd2);
    wait_idle("t1_idle");

    // Table: single-byte frames from several request patterns.
    do_reset();
    exp_frames = 0;
    foreach (vecs[v]) begin
      req_valid = vecs[v].valid;
      for (int k = 0; k < int'(NR); k++) set_byte(k, 8'(8'hA0 + k), 1'b1);
      tx_ready = 1'b1;
      tick();
      check($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
      check($sformatf("vec%0d_out", v), 32'({busy, tx_valid, tx_last, tx_data}),
            32'({1'b1, 1'b1, 1'b1, vecs[v].exp_data}));
      check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_grant));
      tick();
      req_valid = '0;
      exp_frames++;
      check($sformatf("vec%0d_gclr", v), 32'(grant), 32'h0);
      check($sformatf("vec%0d_fcount", v), 32'(frame_count), 32'(exp_frames));
      wait_idle($sformatf("vec%0d_idle", v));
    end

    // All three requesting continuously: two full rounds in order 0,1,2.
    do_reset();
    req_valid = 3'b111;
    for (int k = 0; k < int'(NR); k++) set_byte(k, 8'(k * 64), 1'b0);
    for (int f = 0; f < 6; f++) begin
      int k;
      k = f % 3;
      wait_grant($sformatf("t2_wait%0d", f), gap);
      check($sformatf("t2_grant%0d", f), 32'(grant), 32'(3'b001 << k));
      for (int b = 0; b < 3; b++) begin
        set_byte(k, 8'(k * 64 + (f / 3) * 8 + b), b == 2);
        #1;
        check($sformatf("t2_data%0d_%0d", f, b), 32'({req_ready, tx_data}),
              32'({3'(3'b001 << k), 8'(k * 64 + (f / 3) * 8 + b)}));
        tick();
      end
    end
    req_valid = '0;
    check("t2_fcount", 32'(frame_count), 32'd6);

    // Req2 40-byte frame under random backpressure.
    out_q.delete(); last_seen = 0;
    for (int i = 0; i < 40; i++) in3[i] = 8'($urandom);
    req_valid = 3'b100;
    tx_ready  = 1'b0;
    set_byte(2, in3[0], 1'b0);
    wait_grant("t3_wait", gap);
    check("t3_grant", 32'(grant), 32'h4);
    begin
      int idx, guard;
      logic r;
      idx = 0; guard = 0;
      while (idx < 40 && guard < 400) begin
        r = 1'($urandom_range(0, 1));
        tx_ready = r;
        set_byte(2, in3[idx], idx == 39);
        #1;
        check("t3_ready_mirror", 32'(req_ready), 32'({r, 2'b00}));
        tick();
        if (r) idx++;
        guard++;
      end
      check("t3_done", 32'(idx), 32'd40);
    end
    req_valid = '0;
    tx_ready  = 1'b1;
    check("t3_beats", 32'(out_q.size()), 32'd40);
    check("t3_lasts", 32'(last_seen), 32'd1);
    errs = 0;
    for (int i = 0; i < out_q.size() && i < 40; i++) if (out_q[i] != in3[i]) errs++;
    check("t3_stream", 32'(errs), 32'd0);
    check("t3_fcount", 32'(frame_count), 32'd7);

    // Req0 100-byte frame: truncated at 64, remainder drained.
    req_valid = 3'b001;
    set_byte(0, 8'h00, 1'b0);
    wait_grant("t4_wait", gap);
    out_q.delete(); last_seen = 0; ovr_seen = 0;
    check("t4_grant", 32'(grant), 32'h1);
    for (int b = 0; b < 100; b++) begin
      set_byte(0, 8'(b), b == 99);
      #1;
      if (b < 64)
        check($sformatf("t4_beat%0d", b), 32'({tx_valid, tx_last, req_ready, overrun}),
              32'({1'b1, b == 63, 3'b001, 1'b0}));
      else
        check($sformatf("t4_drain%0d", b), 32'({tx_valid, req_ready, grant, overrun}),
              32'({1'b0, 3'b001, 3'b001, b == 64}));
      tick();
    end
    req_valid = '0;
    check("t4_ovr_pulses", 32'(ovr_seen), 32'd1);
    check("t4_beats", 32'(out_q.size()), 32'd64);
    check("t4_lasts", 32'(last_seen), 32'd1);
    check("t4_fcount", 32'(frame_count), 32'd8);
    check("t4_after", 32'({busy, grant}), 32'({1'b1, 3'b000}));

    // Reset asserted for one clock at byte 10 of a req1 frame.
    req_valid = 3'b010;
    set_byte(1, 8'h00, 1'b0);
    wait_grant("t5_wait", gap);
    check("t5_grant", 32'(grant), 32'h2);
    for (int b = 0; b < 10; b++) begin
      set_byte(1, 8'(b), 1'b0);
      tick();
    end
    set_byte(1, 8'd10, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = '0;
    check_reset_vals("t5_midreset");
    req_valid = 3'b100;
    set_byte(2, 8'h77, 1'b1);
    tick();
    check("t5_new_grant", 32'(grant), 32'h4);
    check("t5_new_out", 32'({tx_valid, tx_last, tx_data}), 32'({1'b1, 1'b1, 8'h77}));
    tick();
    req_valid = '0;
    check("t5_fcount", 32'(frame_count), 32'd1);
    wait_idle("t5_idle");

    // Frame counter wraps from 0xFFFF to 0.
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    check("t6_preload", 32'(frame_count), 32'hFFFF);
    req_valid = 3'b001;
    set_byte(0, 8'h11, 1'b1);
    wait_grant("t6_wait", gap);
    tick();
    req_valid = '0;
    check("t6_wrap", 32'(frame_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
